mmio_peripheral_regs: RTL and testbench

Parametrised memory-mapped peripheral register slave on the picorv32 native memory bus, sitting between the CPU data port and the board I/O (LEDs, keys, switches, color LEDs, 7-segment digit registers). It generalises the fixed register decode in the SoC top to configurable channel counts. It adds byte-strobe writes, sticky key-press events with write-1-to-clear, a 32-bit compare timer, and a level interrupt output.

---
 rtl/mmio_peripheral_regs.sv | 154 +++++++++++++++
 tb/tb_mmio_peripheral_regs.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_peripheral_regs.sv
// Memory-mapped register slave on the picorv32 native bus: board I/O, sticky key
// events, a free-running compare timer and a registered level interrupt.
module mmio_peripheral_regs #(
  parameter int          CLOCK_HZ       = 12_000_000,
  parameter logic [31:0] ID_VALUE       = 32'h0123_4568,
  parameter logic [3:0]  BASE_NIBBLE    = 4'h3,
  parameter int          NUM_LEDS       = 8,
  parameter int          NUM_KEYS       = 8,
  parameter int          NUM_SWITCHES   = 8,
  parameter int          NUM_COLOR_LEDS = 4,
  parameter int          NUM_DIGITS     = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          mem_valid,
  input  logic [31:0]                   mem_addr,
  input  logic [31:0]                   mem_wdata,
  input  logic [3:0]                    mem_wstrb,
  output logic                          mem_ready,
  output logic [31:0]                   mem_rdata,
  input  logic [NUM_KEYS-1:0]           keys,
  input  logic [NUM_SWITCHES-1:0]       switches,
  output logic [NUM_LEDS-1:0]           led_out,
  output logic [3*NUM_COLOR_LEDS-1:0]   color_leds,
  output logic [6*NUM_DIGITS-1:0]       digits,
  output logic                          irq
);

  localparam logic [5:0] OFF_ID         = 6'h00;
  localparam logic [5:0] OFF_LED        = 6'h01;
  localparam logic [5:0] OFF_KEY        = 6'h02;
  localparam logic [5:0] OFF_SWITCH     = 6'h03;
  localparam logic [5:0] OFF_KEY_EVENT  = 6'h04;
  localparam logic [5:0] OFF_IRQ_ENABLE = 6'h05;
  localparam logic [5:0] OFF_COUNTER    = 6'h06;
  localparam logic [5:0] OFF_COMPARE    = 6'h07;
  localparam logic [5:0] OFF_IRQ_STATUS = 6'h08;
  localparam logic [5:0] OFF_CLOCK_HZ   = 6'h09;
  localparam logic [5:0] OFF_COLOR      = 6'h10;
  localparam logic [5:0] OFF_DIGIT      = 6'h18;

  logic                  accept;
  logic                  wr_en;
  logic [5:0]            offset;
  logic [31:0]           bmask;
  logic [31:0]           clr_bits;
  logic [31:0]           rd_word;
  logic [NUM_KEYS-1:0]   key_prev;
  logic [NUM_KEYS-1:0]   key_event;
  logic [NUM_KEYS-1:0]   key_set;
  logic [NUM_KEYS-1:0]   key_clr;
  logic [1:0]            irq_en;
  logic [31:0]           counter;
  logic [31:0]           compare;
  logic                  timer_flag;
  logic                  timer_match;
  logic                  timer_clr;
  logic [2:0]            color_reg [NUM_COLOR_LEDS];
  logic [5:0]            digit_reg [NUM_DIGITS];
  logic                  unused_bits;

  // Blocking on mem_ready spaces accepted requests at least two edges apart.
  assign accept   = mem_valid && !mem_ready && (mem_addr[31:28] == BASE_NIBBLE);
  assign wr_en    = accept && (mem_wstrb != 4'b0000);
  assign offset   = mem_addr[7:2];
  assign bmask    = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
  assign clr_bits = mem_wdata & bmask;

  // A fresh edge and a W1C in the same cycle leave the flag set.
  assign key_set     = keys & ~key_prev;
  assign key_clr     = (wr_en && offset == OFF_KEY_EVENT) ? clr_bits[NUM_KEYS-1:0] : '0;
  assign timer_match = (counter == compare);
  assign timer_clr   = wr_en && (offset == OFF_IRQ_STATUS) && clr_bits[1];

  assign unused_bits = ^{mem_addr[27:8], mem_addr[1:0], clr_bits};

  for (genvar g = 0; g < NUM_COLOR_LEDS; g++) begin : g_color
    assign color_leds[3*g +: 3] = color_reg[g];
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign digits[6*g +: 6] = digit_reg[g];
  end

  always_comb begin
    rd_word = '0;
    case (offset)
      OFF_ID:         rd_word = ID_VALUE;
      OFF_LED:        rd_word[NUM_LEDS-1:0] = led_out;
      OFF_KEY:        rd_word[NUM_KEYS-1:0] = keys;
      OFF_SWITCH:     rd_word[NUM_SWITCHES-1:0] = switches;
      OFF_KEY_EVENT:  rd_word[NUM_KEYS-1:0] = key_event;
      OFF_IRQ_ENABLE: rd_word[1:0] = irq_en;
      OFF_COUNTER:    rd_word = counter;
      OFF_COMPARE:    rd_word = compare;
      OFF_IRQ_STATUS: rd_word[1:0] = {timer_flag, |key_event};
      OFF_CLOCK_HZ:   rd_word = 32'(CLOCK_HZ);
      default:        rd_word = '0;
    endcase
    for (int i = 0; i < NUM_COLOR_LEDS; i++) begin
      if (offset == OFF_COLOR + 6'(i)) rd_word[2:0] = color_reg[i];
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (offset == OFF_DIGIT + 6'(i)) rd_word[5:0] = digit_reg[i];
    end
  end

  // Keeps sampling through reset so a key held across reset raises no event.
  always_ff @(posedge clock) begin
    key_prev <= keys;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
      led_out    <= '0;
      key_event  <= '0;
      irq_en     <= '0;
      counter    <= '0;
      compare    <= 32'hFFFF_FFFF;
      timer_flag <= 1'b0;
      irq        <= 1'b0;
      for (int i = 0; i < NUM_COLOR_LEDS; i++) color_reg[i] <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= '0;
    end else begin
      mem_ready  <= accept;
      mem_rdata  <= accept ? rd_word : '0;
      counter    <= counter + 32'd1;
      key_event  <= (key_event & ~key_clr) | key_set;
      timer_flag <= timer_match | (timer_flag & ~timer_clr);
      irq        <= |({timer_flag, |key_event} & irq_en);

      if (wr_en) begin
        case (offset)
          OFF_LED:        led_out <= (led_out & ~bmask[NUM_LEDS-1:0]) |
                                     (mem_wdata[NUM_LEDS-1:0] & bmask[NUM_LEDS-1:0]);
          OFF_IRQ_ENABLE: irq_en  <= (irq_en & ~bmask[1:0]) | (mem_wdata[1:0] & bmask[1:0]);
          OFF_COMPARE:    compare <= (compare & ~bmask) | (mem_wdata & bmask);
          default:        ;
        endcase
        for (int i = 0; i < NUM_COLOR_LEDS; i++) begin
          if (offset == OFF_COLOR + 6'(i))
            color_reg[i] <= (color_reg[i] & ~bmask[2:0]) | (mem_wdata[2:0] & bmask[2:0]);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (offset == OFF_DIGIT + 6'(i))
            digit_reg[i] <= (digit_reg[i] & ~bmask[5:0]) | (mem_wdata[5:0] & bmask[5:0]);
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_peripheral_regs.sv
// Directed self-checking bench for mmio_peripheral_regs with default parameters.
module tb_mmio_peripheral_regs;

  localparam logic [31:0] A_ID   = 32'h3000_0000;
  localparam logic [31:0] A_LED  = 32'h3000_0004;
  localparam logic [31:0] A_KEY  = 32'h3000_0008;
  localparam logic [31:0] A_SW   = 32'h3000_000C;
  localparam logic [31:0] A_KEV  = 32'h3000_0010;
  localparam logic [31:0] A_IEN  = 32'h3000_0014;
  localparam logic [31:0] A_CNT  = 32'h3000_0018;
  localparam logic [31:0] A_CMP  = 32'h3000_001C;
  localparam logic [31:0] A_IST  = 32'h3000_0020;
  localparam logic [31:0] A_HZ   = 32'h3000_0024;
  localparam logic [31:0] A_UNM  = 32'h3000_0028;
  localparam logic [31:0] A_COL1 = 32'h3000_0044;
  localparam logic [31:0] A_SEG0 = 32'h3000_0060;
  localparam logic [31:0] A_SEG2 = 32'h3000_0068;
  localparam logic [31:0] A_SEG4 = 32'h3000_0070;

  logic        clock;
  logic        reset;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [7:0]  keys;
  logic [7:0]  switches;
  logic [7:0]  led_out;
  logic [11:0] color_leds;
  logic [23:0] digits;
  logic        irq;

  int          test_count = 0;
  int          fail_count = 0;
  logic [31:0] rd;
  logic        rdy;
  logic [31:0] cnt0;
  logic [31:0] cnt1;

  mmio_peripheral_regs dut (
    .clock      (clock),
    .reset      (reset),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .keys       (keys),
    .switches   (switches),
    .led_out    (led_out),
    .color_leds (color_leds),
    .digits     (digits),
    .irq        (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One bus transaction plus the mandatory idle edge; returns data captured in the ready cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, output logic [31:0] rdata,
                               output logic ready);
    @(negedge clock);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    @(posedge clock);
    #1;
    rdata     = mem_rdata;
    ready     = mem_ready;
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = 4'b0000;
    keys      = 8'h01;
    switches  = 8'h5A;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_ready", {31'b0, mem_ready}, 32'd0);
    checkOutput("reset_led", {24'b0, led_out}, 32'd0);
    checkOutput("reset_irq", {31'b0, irq}, 32'd0);
    checkOutput("reset_digits", {8'b0, digits}, 32'd0);
    checkOutput("reset_color", {20'b0, color_leds}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(A_ID, 32'd0, 4'b0000, rd, rdy);
    checkOutput("id_ready", {31'b0, rdy}, 32'd1);
    checkOutput("id_value", rd, 32'h0123_4568);
    applyStimulus(A_CMP, 32'd0, 4'b0000, rd, rdy);
    checkOutput("compare_reset", rd, 32'hFFFF_FFFF);
    applyStimulus(A_KEV, 32'd0, 4'b0000, rd, rdy);
    checkOutput("key_held_through_reset", rd, 32'd0);
    applyStimulus(A_KEY, 32'd0, 4'b0000, rd, rdy);
    checkOutput("key_level", rd, 32'h0000_0001);
    keys = 8'h00;
    applyStimulus(A_SW, 32'd0, 4'b0000, rd, rdy);
    checkOutput("switch_level", rd, 32'h0000_005A);
    applyStimulus(A_HZ, 32'd0, 4'b0000, rd, rdy);
    checkOutput("clock_hz", rd, 32'h00B7_1B00);
    applyStimulus(A_UNM, 32'hFFFF_FFFF, 4'b1111, rd, rdy);
    checkOutput("unmapped_write_ready", {31'b0, rdy}, 32'd1);
    applyStimulus(A_UNM, 32'd0, 4'b0000, rd, rdy);
    checkOutput("unmapped_read", rd, 32'd0);

    applyStimulus(A_LED, 32'h0000_00A5, 4'b0010, rd, rdy);
    checkOutput("led_wrong_strobe", {24'b0, led_out}, 32'd0);
    applyStimulus(A_LED, 32'h0000_00A5, 4'b0001, rd, rdy);
    checkOutput("led_byte0", {24'b0, led_out}, 32'h0000_00A5);
    applyStimulus(A_LED, 32'd0, 4'b0000, rd, rdy);
    checkOutput("led_readback", rd, 32'h0000_00A5);

    applyStimulus(A_SEG2, 32'h0000_002A, 4'b1111, rd, rdy);
    checkOutput("seg2_output", {26'b0, digits[17:12]}, 32'h0000_002A);
    applyStimulus(A_SEG2, 32'd0, 4'b0000, rd, rdy);
    checkOutput("seg2_readback", rd, 32'h0000_002A);
    applyStimulus(A_SEG0, 32'd0, 4'b0000, rd, rdy);
    checkOutput("seg0_readback", rd, 32'd0);
    applyStimulus(A_SEG4, 32'h0000_003F, 4'b1111, rd, rdy);
    checkOutput("seg4_write_ready", {31'b0, rdy}, 32'd1);
    checkOutput("seg4_no_effect", {8'b0, digits}, 32'h0002_A000);
    applyStimulus(A_SEG4, 32'd0, 4'b0000, rd, rdy);
    checkOutput("seg4_readback", rd, 32'd0);

    applyStimulus(A_COL1, 32'hFFFF_FFFF, 4'b1111, rd, rdy);
    checkOutput("color1_output", {20'b0, color_leds}, 32'h0000_0038);
    applyStimulus(A_COL1, 32'd0, 4'b0000, rd, rdy);
    checkOutput("color1_readback", rd, 32'h0000_0007);

    applyStimulus(A_IEN, 32'hFFFF_FFFF, 4'b1111, rd, rdy);
    applyStimulus(A_IEN, 32'd0, 4'b0000, rd, rdy);
    checkOutput("irq_enable_width", rd, 32'h0000_0003);
    applyStimulus(A_IEN, 32'h0000_0001, 4'b0001, rd, rdy);

    @(negedge clock);
    keys = 8'h08;
    @(posedge clock);
    #1;
    checkOutput("key_irq_first_cycle", {31'b0, irq}, 32'd0);
    @(posedge clock);
    #1;
    checkOutput("key_irq_second_cycle", {31'b0, irq}, 32'd1);
    @(negedge clock);
    keys = 8'h00;
    applyStimulus(A_KEV, 32'd0, 4'b0000, rd, rdy);
    checkOutput("key_event_set", rd, 32'h0000_0008);
    applyStimulus(A_IST, 32'd0, 4'b0000, rd, rdy);
    checkOutput("irq_status_key", rd, 32'h0000_0001);
    applyStimulus(A_KEV, 32'h0000_0008, 4'b0001, rd, rdy);
    checkOutput("key_w1c_irq", {31'b0, irq}, 32'd0);
    applyStimulus(A_KEV, 32'd0, 4'b0000, rd, rdy);
    checkOutput("key_w1c_cleared", rd, 32'd0);

    @(negedge clock);
    keys      = 8'h08;
    mem_valid = 1'b1;
    mem_addr  = A_KEV;
    mem_wdata = 32'h0000_0008;
    mem_wstrb = 4'b0001;
    @(posedge clock);
    #1;
    checkOutput("set_wins_ready", {31'b0, mem_ready}, 32'd1);
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
    keys      = 8'h00;
    @(posedge clock);
    #1;
    applyStimulus(A_KEV, 32'd0, 4'b0000, rd, rdy);
    checkOutput("set_wins_over_w1c", rd, 32'h0000_0008);
    applyStimulus(A_KEV, 32'h0000_00FF, 4'b0001, rd, rdy);
    applyStimulus(A_IEN, 32'h0000_0002, 4'b0001, rd, rdy);

    applyStimulus(A_CNT, 32'd0, 4'b0000, cnt0, rdy);
    applyStimulus(A_CNT, 32'd0, 4'b0000, cnt1, rdy);
    checkOutput("counter_step", cnt1, cnt0 + 32'd2);
    applyStimulus(A_CMP, cnt1 + 32'd22, 4'b1111, rd, rdy);
    repeat (19) @(posedge clock);
    #1;
    checkOutput("timer_irq_before", {31'b0, irq}, 32'd0);
    @(posedge clock);
    #1;
    checkOutput("timer_irq_rise", {31'b0, irq}, 32'd1);
    applyStimulus(A_IST, 32'd0, 4'b0000, rd, rdy);
    checkOutput("irq_status_timer", rd, 32'h0000_0002);
    applyStimulus(A_IST, 32'h0000_0002, 4'b0001, rd, rdy);
    checkOutput("timer_w1c_irq", {31'b0, irq}, 32'd0);
    applyStimulus(A_IST, 32'd0, 4'b0000, rd, rdy);
    checkOutput("timer_w1c_status", rd, 32'd0);

    @(negedge clock);
    mem_valid = 1'b1;
    mem_addr  = A_LED;
    mem_wdata = 32'h0000_0011;
    mem_wstrb = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("b2b_ready_%0d", i), {31'b0, mem_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i == 0) mem_wdata = 32'h0000_0022;
      if (i == 2) mem_wdata = 32'h0000_0033;
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
    @(posedge clock);
    #1;
    checkOutput("b2b_led_final", {24'b0, led_out}, 32'h0000_0022);

    applyStimulus(32'h2000_0004, 32'h0000_0055, 4'b0001, rd, rdy);
    checkOutput("foreign_no_ready", {31'b0, rdy}, 32'd0);
    checkOutput("foreign_no_write", {24'b0, led_out}, 32'h0000_0022);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
